// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and helpers for the UART transmit scheduler: FSM state encoding,
// default frame width and the round-robin index helper.
package uart_tx_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } sched_state_t;

    localparam int DEFAULT_DATA_SIZE = 8;

    // Requester index reached after stepping 'step' places past 'last', wrapping at n.
    function automatic int rr_index(input int last, input int step, input int n);
        return (last + step) % n;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, wrapping,
// with last_grant itself considered last.
module uart_tx_scheduler_rr_arbiter
    import uart_tx_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               any_req
);

    logic found;

    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
        grant_idx = last_grant;
        found     = 1'b0;
        any_req   = |req;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req[rr_index(int'(last_grant), k, NUM_REQ)]) begin
                found     = 1'b1;
                grant_idx = ID_W'(rr_index(int'(last_grant), k, NUM_REQ));
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_REQ byte requesters: round-robin grants with a
// burst limit, a capture register for tx_data and tx_on sequencing against data_seen.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 16,
    localparam int ID_W     = $clog2(NUM_REQ),
    localparam int BC_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           tx_data_seen,
    input  logic                           tx_busy,
    output logic                           tx_on,
    output logic [DATA_SIZE-1:0]           tx_data,
    output logic [ID_W-1:0]                grant_id,
    output logic                           sched_busy,
    output logic [CNT_W-1:0]               frame_cnt
);

    sched_state_t         state_q, state_d;
    logic                 tx_on_q, tx_on_d;
    logic [DATA_SIZE-1:0] tx_data_q, tx_data_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic [ID_W-1:0]      grant_id_q, grant_id_d;
    logic [BC_W-1:0]      burst_cnt_q, burst_cnt_d;
    logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
    logic                 ds_q;

    logic                 ds_rise, ds_fall;
    logic [ID_W-1:0]      arb_grant;
    logic                 arb_any;
    logic                 capture;
    logic [ID_W-1:0]      sel;
    logic [DATA_SIZE-1:0] cap_data;

    uart_tx_scheduler_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req        (req_valid),
        .last_grant (grant_id_q),
        .grant_idx  (arb_grant),
        .any_req    (arb_any)
    );

    assign ds_rise = tx_data_seen & ~ds_q;
    assign ds_fall = ~tx_data_seen & ds_q;

    always_comb begin
        state_d     = state_q;
        tx_on_d     = 1'b0;
        tx_data_d   = tx_data_q;
        req_ready_d = '0;
        grant_id_d  = grant_id_q;
        burst_cnt_d = burst_cnt_q;
        frame_cnt_d = frame_cnt_q;
        capture     = 1'b0;
        sel         = arb_grant;
        cap_data    = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    capture     = 1'b1;
                    burst_cnt_d = BC_W'(1);
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Request stays up until the transmitter opens its start-bit window.
                tx_on_d = ~ds_rise;
                if (ds_rise) begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // End of the start bit: the transmitter has taken tx_data, so the next byte may load.
                if (ds_fall) begin
                    if (req_valid[grant_id_q] && burst_cnt_q < BC_W'(MAX_BURST)) begin
                        capture     = 1'b1;
                        sel         = grant_id_q;
                        burst_cnt_d = burst_cnt_q + 1'b1;
                        state_d     = ST_LOAD;
                    end else if (arb_any) begin
                        capture     = 1'b1;
                        burst_cnt_d = BC_W'(1);
                        state_d     = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel == ID_W'(i)) cap_data = req_data[i*DATA_SIZE +: DATA_SIZE];
        end

        if (capture) begin
            req_ready_d[sel] = 1'b1;
            grant_id_d       = sel;
            tx_data_d        = cap_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tx_on_q     <= 1'b0;
            tx_data_q   <= '0;
            req_ready_q <= '0;
            grant_id_q  <= ID_W'(NUM_REQ - 1);
            burst_cnt_q <= '0;
            frame_cnt_q <= '0;
            ds_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_on_q     <= tx_on_d;
            tx_data_q   <= tx_data_d;
            req_ready_q <= req_ready_d;
            grant_id_q  <= grant_id_d;
            burst_cnt_q <= burst_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            ds_q        <= tx_data_seen;
        end
    end

    assign tx_on      = tx_on_q;
    assign tx_data    = tx_data_q;
    assign req_ready  = req_ready_q;
    assign grant_id   = grant_id_q;
    assign frame_cnt  = frame_cnt_q;
    assign sched_busy = (state_q != ST_IDLE) | tx_busy;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: two instances (MAX_BURST=4/CNT_W=4 and MAX_BURST=1/CNT_W=16),
// each driving a behavioural transmitter (parity on, 16 clks/bit) and quota-based requesters.
module tb_uart_tx_scheduler;

    localparam int NR         = 4;
    localparam int DS         = 8;
    localparam int BIT_CLKS   = 16;
    localparam int FRAME_CLKS = 11 * BIT_CLKS;

    typedef struct {
        int         k;
        logic [7:0] data;
        bit         b2b;
    } frame_exp_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    int         quota  [2][NR];
    int         served [2][NR];
    logic [7:0] base   [2][NR];

    logic [NR-1:0]    rv [2];
    logic [NR*DS-1:0] rd [2];
    logic [NR-1:0]    rr [2];
    logic [1:0]       tx_on;
    logic [1:0]       sbusy;
    logic [7:0]       txd [2];
    logic [1:0]       gid [2];
    logic [3:0]       fc_a;
    logic [15:0]      fc_b;

    logic [1:0] m_busy;
    logic [1:0] m_ds;
    int         m_bit [2];
    int         m_clk [2];
    logic [7:0] log_data  [2][64];
    int         log_start [2][64];
    int         log_n     [2] = '{0, 0};

    frame_exp_t exp_tab [17];

    uart_tx_scheduler #(.NUM_REQ(NR), .DATA_SIZE(DS), .MAX_BURST(4), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_data(rd[0]), .req_ready(rr[0]),
        .tx_data_seen(m_ds[0]), .tx_busy(m_busy[0]), .tx_on(tx_on[0]), .tx_data(txd[0]),
        .grant_id(gid[0]), .sched_busy(sbusy[0]), .frame_cnt(fc_a)
    );

    uart_tx_scheduler #(.NUM_REQ(NR), .DATA_SIZE(DS), .MAX_BURST(1), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_data(rd[1]), .req_ready(rr[1]),
        .tx_data_seen(m_ds[1]), .tx_busy(m_busy[1]), .tx_on(tx_on[1]), .tx_data(txd[1]),
        .grant_id(gid[1]), .sched_busy(sbusy[1]), .frame_cnt(fc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Requester i of instance k offers bytes base+0, base+1, ... while served < quota.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NR; i++) begin
                rv[k][i]          = quota[k][i] > served[k][i];
                rd[k][i*DS +: DS] = base[k][i] + 8'(served[k][i]);
            end
        end
    end

    // Transmitter model: start bit (data_seen high), 8 data, parity, stop; restarts at the end
    // of stop when tx_on is already high. Byte is taken on the last clock of the start bit.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_busy[k] <= 1'b0;
                m_ds[k]   <= 1'b0;
                m_bit[k]  <= 0;
                m_clk[k]  <= 0;
                for (int i = 0; i < NR; i++) served[k][i] <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < NR; i++) begin
                    if (rr[k][i]) served[k][i] <= served[k][i] + 1;
                end
                if (!m_busy[k]) begin
                    if (tx_on[k]) begin
                        m_busy[k] <= 1'b1;
                        m_ds[k]   <= 1'b1;
                        m_bit[k]  <= 0;
                        m_clk[k]  <= 0;
                        log_start[k][log_n[k]] <= cyc;
                    end
                end else if (m_clk[k] == BIT_CLKS - 1) begin
                    m_clk[k] <= 0;
                    if (m_bit[k] == 0) begin
                        m_ds[k] <= 1'b0;
                        log_data[k][log_n[k]] <= txd[k];
                        log_n[k] <= log_n[k] + 1;
                    end
                    if (m_bit[k] == 10) begin
                        if (tx_on[k]) begin
                            m_ds[k]  <= 1'b1;
                            m_bit[k] <= 0;
                            log_start[k][log_n[k]] <= cyc;
                        end else begin
                            m_busy[k] <= 1'b0;
                        end
                    end else begin
                        m_bit[k] <= m_bit[k] + 1;
                    end
                end else begin
                    m_clk[k] <= m_clk[k] + 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic check_reset(input int k);
        check($sformatf("rst_tx_on_%0d", k), 32'(tx_on[k]), 0);
        check($sformatf("rst_tx_data_%0d", k), 32'(txd[k]), 0);
        check($sformatf("rst_req_ready_%0d", k), 32'(rr[k]), 0);
        check($sformatf("rst_grant_id_%0d", k), 32'(gid[k]), NR - 1);
        check($sformatf("rst_sched_busy_%0d", k), 32'(sbusy[k]), 0);
    endtask

    task automatic wait_idle(input int k, input int limit);
        int n;
        n = 0;
        repeat (3) @(negedge clk);
        while (sbusy[k] && n < limit) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("idle_in_time_%0d", k), 32'(n < limit), 1);
    endtask

    task automatic wait_ds(input int k, input int limit);
        int n;
        n = 0;
        while (!m_ds[k] && n < limit) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("ds_in_time_%0d", k), 32'(n < limit), 1);
    endtask

    task automatic check_frames(input int tab_from, input int n, input int log_from);
        for (int j = 0; j < n; j++) begin
            frame_exp_t e;
            e = exp_tab[tab_from + j];
            check($sformatf("frame_data_%0d", tab_from + j),
                  32'(log_data[e.k][log_from + j]), 32'(e.data));
            if (e.b2b)
                check($sformatf("frame_gap_%0d", tab_from + j),
                      32'(log_start[e.k][log_from + j] - log_start[e.k][log_from + j - 1]),
                      FRAME_CLKS);
        end
    endtask

    initial begin
        int li, n, bad;

        exp_tab[0]  = '{0, 8'hA5, 1'b0};
        exp_tab[1]  = '{1, 8'h10, 1'b0};
        exp_tab[2]  = '{1, 8'h20, 1'b1};
        exp_tab[3]  = '{1, 8'h30, 1'b1};
        exp_tab[4]  = '{1, 8'h40, 1'b1};
        exp_tab[5]  = '{1, 8'h11, 1'b1};
        exp_tab[6]  = '{0, 8'hA6, 1'b0};
        exp_tab[7]  = '{0, 8'hA7, 1'b1};
        exp_tab[8]  = '{0, 8'hA8, 1'b1};
        exp_tab[9]  = '{0, 8'hA9, 1'b1};
        exp_tab[10] = '{0, 8'hB0, 1'b1};
        exp_tab[11] = '{0, 8'hAA, 1'b1};
        exp_tab[12] = '{0, 8'hAB, 1'b1};
        exp_tab[13] = '{0, 8'hD0, 1'b0};
        exp_tab[14] = '{0, 8'hC0, 1'b1};
        exp_tab[15] = '{0, 8'h55, 1'b0};
        exp_tab[16] = '{0, 8'h66, 1'b1};

        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NR; i++) begin
                quota[k][i] = 0;
                base[k][i]  = 8'(16 * (i + 1));
            end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset(0);
        check_reset(1);
        check("rst_frame_cnt_a", 32'(fc_a), 0);
        check("rst_frame_cnt_b", 32'(fc_b), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte: one-cycle ready pulse, tx_on one cycle later, then back to idle.
        li = log_n[0];
        base[0][0]  = 8'hA5;
        quota[0][0] = 1;
        @(posedge clk); #1;
        check("t1_ready", 32'(rr[0]), 32'b0001);
        check("t1_tx_data", 32'(txd[0]), 32'hA5);
        check("t1_grant", 32'(gid[0]), 0);
        check("t1_tx_on_late", 32'(tx_on[0]), 0);
        @(posedge clk); #1;
        check("t1_ready_pulse", 32'(rr[0]), 0);
        check("t1_tx_on", 32'(tx_on[0]), 1);
        wait_idle(0, 400);
        check_frames(0, 1, li);
        check("t1_frame_cnt", 32'(fc_a), 1);

        // Pure round robin, all four valid.
        li = log_n[1];
        quota[1][0] = 2;
        quota[1][1] = 1;
        quota[1][2] = 1;
        quota[1][3] = 1;
        wait_idle(1, 1500);
        check_frames(1, 5, li);
        check("t2_grant", 32'(gid[1]), 0);

        // Burst limit: req0 alone first, then req1 joins.
        li = log_n[0];
        quota[0][0] = 7;
        @(negedge clk);
        base[0][1]  = 8'hB0;
        quota[0][1] = 1;
        wait_idle(0, 2000);
        check_frames(6, 7, li);
        check("t3_frame_cnt", 32'(fc_a), 8);

        // New requester mid-HOLD: tx_data stays until the start bit ends.
        li = log_n[0];
        base[0][3]  = 8'hD0;
        quota[0][3] = 1;
        wait_ds(0, 400);
        base[0][2]  = 8'hC0;
        quota[0][2] = 1;
        bad = 0;
        n = 0;
        while (m_ds[0] && n < 40) begin
            if (txd[0] != 8'hD0) bad++;
            @(negedge clk);
            n++;
        end
        check("t4_hold_stable", 32'(bad), 0);
        check("t4_at_fall", 32'(txd[0]), 32'hD0);
        @(posedge clk); #1;
        check("t4_ready", 32'(rr[0]), 32'b0100);
        check("t4_tx_data", 32'(txd[0]), 32'hC0);
        wait_idle(0, 800);
        check_frames(13, 2, li);

        // Reset with A in LOAD and B mid-frame.
        base[1][2]  = 8'h70;
        quota[1][2] = 3;
        wait_ds(1, 400);
        repeat (60) @(negedge clk);
        check("t5_b_cnt_before", 32'(fc_b), 6);
        quota[0][1] = 2;
        @(posedge clk); #1;
        check("t5_a_load_ready", 32'(rr[0]), 32'b0010);
        check("t5_a_load_data", 32'(txd[0]), 32'hB1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset(0);
        check_reset(1);
        check("t5_frame_cnt_a", 32'(fc_a), 0);
        check("t5_frame_cnt_b", 32'(fc_b), 0);
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NR; i++) quota[k][i] = 0;
        base[0][0] = 8'h55;
        base[0][1] = 8'h66;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        li = log_n[0];
        quota[0][0] = 1;
        quota[0][1] = 1;
        @(posedge clk); #1;
        check("t5_first_grant", 32'(gid[0]), 0);
        check("t5_first_data", 32'(txd[0]), 32'h55);
        wait_idle(0, 800);
        check_frames(15, 2, li);
        check("t5_frame_cnt", 32'(fc_a), 2);

        // frame_cnt wrap with CNT_W=4, single requester re-granted across bursts.
        li = log_n[0];
        quota[0][3] = 14;
        n = 0;
        while (fc_a != 4'd15 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("t6_reach_15", 32'(fc_a), 15);
        wait_idle(0, 800);
        check("t6_wrap", 32'(fc_a), 0);
        check("t6_frames", 32'(log_n[0] - li), 14);
        check("t6_last_data", 32'(log_data[0][li + 13]), 32'hDD);
        check("t6_grant", 32'(gid[0]), 3);
        bad = 0;
        for (int j = 1; j < 14; j++)
            if (log_start[0][li + j] - log_start[0][li + j - 1] != FRAME_CLKS) bad++;
        check("t6_no_gaps", 32'(bad), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
